cpu_trace_packer: RTL and testbench

//  On-chip producer of the per-cycle CPU state that the simulation bench prints today: PC, stall and flush counts.

---
 rtl/cpu_trace_packer_pkg.sv | 24 ++
 rtl/cpu_trace_packer_fifo.sv | 49 ++++
 rtl/cpu_trace_packer.sv | 172 +++++++++++++++++
 tb/tb_cpu_trace_packer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_packer_pkg.sv
// Shared types and header layout for the CPU trace packer.
package cpu_trace_pkg;

  localparam logic [3:0] TRACE_TAG_DEFAULT = 4'hA;

  localparam int HDR_TAG_LSB   = 28;
  localparam int HDR_STALL_BIT = 27;
  localparam int HDR_FLUSH_BIT = 26;
  localparam int HDR_MEMWR_BIT = 25;
  localparam int HDR_CYCLE_W   = 24;

  typedef enum logic [2:0] {IDLE, HDR, PC, ADDR, DATA} trace_state_e;

  typedef struct packed {
    logic [HDR_CYCLE_W-1:0] cycle;
    logic                   stall;
    logic                   flush;
    logic                   memwr;
    logic [31:0]            pc;
    logic [31:0]            addr;
    logic [31:0]            data;
  } trace_rec_t;

endpackage

// File: rtl/cpu_trace_packer_fifo.sv
// Single-clock FIFO of trace records; full/empty told apart by an extra pointer bit.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  trace_rec_t wdata_i,
  output logic       full_o,
  output logic       empty_o,
  output trace_rec_t rdata_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  trace_rec_t  mem_q [FIFO_DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (rst_i && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cpu_trace_packer.sv
// Samples CPU PC/stall/flush each started cycle and streams packed trace words.
// Define TRACE_MEMWR_EN to add memory-write capture (addr/data words per write record).
module cpu_trace_packer
  import cpu_trace_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         CNT_W      = 32,
  parameter logic [3:0] TRACE_TAG  = TRACE_TAG_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             stall_i,
  input  logic             flush_i,
`ifdef TRACE_MEMWR_EN
  input  logic             mem_wr_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_i,
`endif
  output logic [31:0]      trace_data_o,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             overflow_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] pack_hdr(input trace_rec_t r);
    logic [31:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 4]     = TRACE_TAG;
    h[HDR_STALL_BIT]        = r.stall;
    h[HDR_FLUSH_BIT]        = r.flush;
    h[HDR_MEMWR_BIT]        = r.memwr;
    h[HDR_CYCLE_W-1:0]      = r.cycle;
    return h;
  endfunction

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  trace_state_e state_q;
  logic [31:0]  data_q;
  logic [31:0]  pc_q, addr_q, mdata_q;
  logic         memwr_q;

  trace_rec_t wrec, fifo_rdata;
  logic       fifo_full, fifo_empty, fifo_pop;

  always_comb begin
    wrec       = '0;
    wrec.cycle = HDR_CYCLE_W'(cycle_cnt_q);
    wrec.stall = stall_i;
    wrec.flush = flush_i;
    wrec.pc    = pc_i;
`ifdef TRACE_MEMWR_EN
    wrec.memwr = mem_wr_i;
    wrec.addr  = mem_addr_i;
    wrec.data  = mem_data_i;
`endif
  end

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  trace_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (start_i),
    .pop_i   (fifo_pop),
    .wdata_i (wrec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  // A push into a full buffer is lost even if the serializer pops on the same edge.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    if (start_i) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
      if (stall_i) stall_cnt_d = sat_inc(stall_cnt_q);
      if (flush_i) flush_cnt_d = sat_inc(flush_cnt_q);
      if (fifo_full) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      mdata_q <= '0;
      memwr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          data_q  <= pack_hdr(fifo_rdata);
          pc_q    <= fifo_rdata.pc;
          addr_q  <= fifo_rdata.addr;
          mdata_q <= fifo_rdata.data;
          memwr_q <= fifo_rdata.memwr;
          state_q <= HDR;
        end
        HDR: if (trace_ready_i) begin
          data_q  <= pc_q;
          state_q <= PC;
        end
        PC: if (trace_ready_i) begin
          if (memwr_q) begin
            data_q  <= addr_q;
            state_q <= ADDR;
          end else begin
            data_q  <= '0;
            state_q <= IDLE;
          end
        end
        ADDR: if (trace_ready_i) begin
          data_q  <= mdata_q;
          state_q <= DATA;
        end
        DATA: if (trace_ready_i) begin
          data_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trace_data_o  = data_q;
  assign trace_valid_o = (state_q != IDLE);
  assign cycle_cnt_o   = cycle_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_cpu_trace_packer.sv
// Directed self-checking bench for cpu_trace_packer (default build; memwr case when TRACE_MEMWR_EN is defined).
module tb_cpu_trace_packer;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stall_i, flush_i, trace_ready_i;
  logic [31:0] pc_i;
  logic [31:0] trace_data_o;
  logic        trace_valid_o;
  logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o, drop_cnt_o;
  logic        overflow_o;
`ifdef TRACE_MEMWR_EN
  logic        mem_wr_i;
  logic [31:0] mem_addr_i, mem_data_i;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cpu_trace_packer #(.FIFO_DEPTH(8), .CNT_W(32), .TRACE_TAG(4'hA)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_i          (pc_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
`ifdef TRACE_MEMWR_EN
    .mem_wr_i      (mem_wr_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
`endif
    .trace_data_o  (trace_data_o),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .cycle_cnt_o   (cycle_cnt_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
    .overflow_o    (overflow_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    trace_ready_i = 1'b0; pc_i = '0;
`ifdef TRACE_MEMWR_EN
    mem_wr_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
`endif
    step();
    step();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", trace_valid_o); end
    checks++; if (trace_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", trace_data_o); end
    start_i = 1'b1;
    for (int i = 0; i < 12; i++) begin pc_i = 32'h40 + i; step(); end
    start_i = 1'b0;
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", trace_valid_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL pre_reset_overflow: got %b expected 1", overflow_o); end
    rst_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", trace_valid_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b expected 0", overflow_o); end
    checks++; if ({cycle_cnt_o, stall_cnt_o, flush_cnt_o, drop_cnt_o} !== 128'h0) begin
      errors++; $display("FAIL midreset_counters: got %h %h %h %h expected all 0", cycle_cnt_o, stall_cnt_o, flush_cnt_o, drop_cnt_o);
    end
    step();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_buffer_empty: got valid %b expected 0", trace_valid_o); end
  endtask

  task automatic test_single();
    do_reset();
    trace_ready_i = 1'b1; start_i = 1'b1; pc_i = 32'h10; stall_i = 1'b1;
    step();
    start_i = 1'b0; stall_i = 1'b0;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency0: got valid %b expected 0", trace_valid_o); end
    checks++; if (cycle_cnt_o !== 32'd1) begin errors++; $display("FAIL single_cycle_cnt: got %0d expected 1", cycle_cnt_o); end
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL single_stall_cnt: got %0d expected 1", stall_cnt_o); end
    step();
    checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'hA8000000) begin
      errors++; $display("FAIL single_hdr: got valid %b data %h expected 1 A8000000", trace_valid_o, trace_data_o);
    end
    step();
    checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'h00000010) begin
      errors++; $display("FAIL single_pc: got valid %b data %h expected 1 00000010", trace_valid_o, trace_data_o);
    end
    step();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL single_end: got valid %b expected 0", trace_valid_o); end
    checks++; if (flush_cnt_o !== 32'd0) begin errors++; $display("FAIL single_flush_cnt: got %0d expected 0", flush_cnt_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < 20; i++) begin pc_i = 32'h100 + 32'(i) * 4; step(); end
    start_i = 1'b0;
    checks++; if (drop_cnt_o !== 32'd11) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 11", drop_cnt_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
    checks++; if (cycle_cnt_o !== 32'd20) begin errors++; $display("FAIL ovf_cycle_cnt: got %0d expected 20", cycle_cnt_o); end
    checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'hA0000000) begin
      errors++; $display("FAIL ovf_first_hdr: got valid %b data %h expected 1 A0000000", trace_valid_o, trace_data_o);
    end
  endtask

  task automatic test_hold_and_drain();
    int   nvalid;
    logic [31:0] last_hdr;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'hA0000000) begin
        errors++; $display("FAIL hold_hdr[%0d]: got valid %b data %h expected 1 A0000000", i, trace_valid_o, trace_data_o);
      end
    end
    trace_ready_i = 1'b1;
    step();
    checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'h00000100) begin
      errors++; $display("FAIL hold_adv_pc: got valid %b data %h expected 1 00000100", trace_valid_o, trace_data_o);
    end
    nvalid = 0; last_hdr = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (trace_valid_o) begin
        nvalid++;
        if (trace_data_o[31:28] == 4'hA) last_hdr = trace_data_o;
      end
    end
    checks++; if (nvalid != 16) begin errors++; $display("FAIL drain_words: got %0d expected 16", nvalid); end
    checks++; if (last_hdr !== 32'hA0000008) begin errors++; $display("FAIL drain_last_hdr: got %h expected A0000008", last_hdr); end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL drain_idle: got valid %b expected 0", trace_valid_o); end
    checks++; if (drop_cnt_o !== 32'd11) begin errors++; $display("FAIL drain_drop_hold: got %0d expected 11", drop_cnt_o); end
  endtask

  task automatic test_flush();
    logic [31:0] got[$];
    logic [31:0] exp_w[6];
    exp_w = '{32'hA4000000, 32'h200, 32'hA4000001, 32'h204, 32'hA4000002, 32'h208};
    do_reset();
    trace_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start_i = (i < 3); flush_i = (i < 3); pc_i = 32'h200 + 32'(i) * 4;
      step();
      if (trace_valid_o) got.push_back(trace_data_o);
    end
    start_i = 1'b0; flush_i = 1'b0;
    checks++; if (flush_cnt_o !== 32'd3) begin errors++; $display("FAIL flush_cnt: got %0d expected 3", flush_cnt_o); end
    checks++; if (cycle_cnt_o !== 32'd3) begin errors++; $display("FAIL flush_cycle_cnt: got %0d expected 3", cycle_cnt_o); end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL flush_word_count: got %0d expected 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= got.size()) begin errors++; $display("FAIL flush_word[%0d]: got none expected %h", k, exp_w[k]); end
      else if (got[k] !== exp_w[k]) begin errors++; $display("FAIL flush_word[%0d]: got %h expected %h", k, got[k], exp_w[k]); end
    end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL flush_idle: got valid %b expected 0", trace_valid_o); end
  endtask

`ifdef TRACE_MEMWR_EN
  task automatic test_memwr();
    logic [31:0] got[$];
    logic [31:0] exp_w[4];
    exp_w = '{32'hA2000000, 32'h20, 32'h4, 32'h5};
    do_reset();
    trace_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 0); mem_wr_i = (i == 0); mem_addr_i = 32'h4; mem_data_i = 32'h5; pc_i = 32'h20;
      step();
      if (trace_valid_o) got.push_back(trace_data_o);
    end
    start_i = 1'b0; mem_wr_i = 1'b0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL memwr_word_count: got %0d expected 4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size()) begin errors++; $display("FAIL memwr_word[%0d]: got none expected %h", k, exp_w[k]); end
      else if (got[k] !== exp_w[k]) begin errors++; $display("FAIL memwr_word[%0d]: got %h expected %h", k, got[k], exp_w[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_hold_and_drain();
    test_flush();
`ifdef TRACE_MEMWR_EN
    test_memwr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
